// File: rtl/poly_pkg.sv
// Shared types and constants for the polynomial sweep driver.
//   sweep_state_t : top-level sequencer states
//   operand_t     : operand slot being loaded into the evaluator (A, B, C, X)
//   WIDTH_DEF     : default data width, matching the evaluator
package poly_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StGap,
        StWaitRes,
        StOutput,
        StFinish
    } sweep_state_t;

    typedef enum logic [1:0] {
        OP_A,
        OP_B,
        OP_C,
        OP_X
    } operand_t;

    // Operand order is fixed: A, B, C, X. Caller guarantees op != OP_X.
    function automatic operand_t next_operand(operand_t op);
        return operand_t'(op + 2'd1);
    endfunction

endpackage

// File: rtl/poly_go_pulser.sv
// Go-phase timer for one operand load.
// A load strobe starts a high phase of GO_HIGH_CYCLES with go=1, followed by a
// low phase of GO_LOW_CYCLES with go=0.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : start a new high/low phase pair
//   go         : registered Go level
//   high_done  : last cycle of the high phase
//   low_done   : last cycle of the low phase (whole operand phase complete)
module poly_go_pulser #(
    parameter int unsigned GO_HIGH_CYCLES = 1,
    parameter int unsigned GO_LOW_CYCLES  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic go,
    output logic high_done,
    output logic low_done
);

    typedef enum logic [1:0] {PhIdle, PhHigh, PhLow} phase_t;

    phase_t      phase;
    logic [15:0] cnt;

    assign high_done = (phase == PhHigh) && (cnt == 16'(GO_HIGH_CYCLES - 1));
    assign low_done  = (phase == PhLow) && (cnt == 16'(GO_LOW_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PhIdle;
            cnt   <= '0;
            go    <= 1'b0;
        end else if (load) begin
            phase <= PhHigh;
            cnt   <= '0;
            go    <= 1'b1;
        end else begin
            unique case (phase)
                PhHigh: begin
                    if (high_done) begin
                        phase <= PhLow;
                        cnt   <= '0;
                        go    <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PhLow: begin
                    if (low_done) begin
                        phase <= PhIdle;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    phase <= PhIdle;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/poly_sweep_driver.sv
// Sequencer/collector for the polynomial evaluator part2.
// For each X of a sweep, serially loads A, B, C, X via Go/DataIn, waits for
// ResultValid, and emits (result, X) on a valid/ready stream.
// Optional feature: define POLY_SWEEP_ACCUM_EN to add a 16-bit `accum` output
// holding the wrapping sum of all transferred results of the current sweep.
// Ports:
//   Clock, Reset                  : clock, asynchronous active-high reset
//   start, coef_a/b/c, x_start,
//   x_step, x_count               : sweep request, captured in idle
//   busy, done, error             : status (done is a pulse, error is sticky)
//   eval_go, eval_data            : to part2 Go / DataIn
//   eval_result, eval_valid       : from part2 DataResult / ResultValid
//   res_valid, res_ready,
//   res_data, res_x               : result stream
module poly_sweep_driver
    import poly_pkg::*;
#(
    parameter int unsigned WIDTH          = WIDTH_DEF,
    parameter int unsigned GO_HIGH_CYCLES = 1,
    parameter int unsigned GO_LOW_CYCLES  = 1,
    parameter int unsigned TIMEOUT        = 15
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] coef_a,
    input  logic [WIDTH-1:0] coef_b,
    input  logic [WIDTH-1:0] coef_c,
    input  logic [WIDTH-1:0] x_start,
    input  logic [WIDTH-1:0] x_step,
    input  logic [7:0]       x_count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             eval_go,
    output logic [WIDTH-1:0] eval_data,
    input  logic [WIDTH-1:0] eval_result,
    input  logic             eval_valid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [WIDTH-1:0] res_x
`ifdef POLY_SWEEP_ACCUM_EN
    ,
    output logic [15:0]      accum
`endif
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    sweep_state_t      state;
    operand_t          idx;
    logic [WIDTH-1:0]  a_q, b_q, c_q, step_q, x_cur;
    logic [7:0]        remaining;
    logic [TCNT_W-1:0] tcnt;
    logic              load, high_done, low_done;

    function automatic logic [WIDTH-1:0] operand_value(operand_t op);
        unique case (op)
            OP_A:    return a_q;
            OP_B:    return b_q;
            OP_C:    return c_q;
            default: return x_cur;
        endcase
    endfunction

    // Strobe the pulser on every transition into DRIVE.
    always_comb begin
        load = 1'b0;
        unique case (state)
            StIdle:   load = start && (x_count != 8'd0);
            StGap:    load = low_done && (idx != OP_X);
            StOutput: load = res_ready && (remaining != 8'd1);
            default:  load = 1'b0;
        endcase
    end

    poly_go_pulser #(
        .GO_HIGH_CYCLES (GO_HIGH_CYCLES),
        .GO_LOW_CYCLES  (GO_LOW_CYCLES)
    ) u_pulser (
        .clk       (Clock),
        .rst       (Reset),
        .load      (load),
        .go        (eval_go),
        .high_done (high_done),
        .low_done  (low_done)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= StIdle;
            idx       <= OP_A;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            step_q    <= '0;
            x_cur     <= '0;
            remaining <= '0;
            tcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            eval_data <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_x     <= '0;
`ifdef POLY_SWEEP_ACCUM_EN
            accum     <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        a_q       <= coef_a;
                        b_q       <= coef_b;
                        c_q       <= coef_c;
                        step_q    <= x_step;
                        x_cur     <= x_start;
                        remaining <= x_count;
                        error     <= 1'b0;
                        busy      <= 1'b1;
`ifdef POLY_SWEEP_ACCUM_EN
                        accum     <= '0;
`endif
                        if (x_count == 8'd0) begin
                            state <= StFinish;
                            done  <= 1'b1;
                        end else begin
                            state     <= StDrive;
                            idx       <= OP_A;
                            eval_data <= coef_a;
                        end
                    end
                end
                StDrive: begin
                    if (high_done) state <= StGap;
                end
                StGap: begin
                    if (low_done) begin
                        if (idx != OP_X) begin
                            idx       <= next_operand(idx);
                            eval_data <= operand_value(next_operand(idx));
                            state     <= StDrive;
                        end else begin
                            tcnt  <= '0;
                            state <= StWaitRes;
                        end
                    end
                end
                StWaitRes: begin
                    if (eval_valid) begin
                        res_data  <= eval_result;
                        res_x     <= x_cur;
                        res_valid <= 1'b1;
                        state     <= StOutput;
                    end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                        // Abort the whole sweep; the pending point is dropped.
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= StFinish;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                StOutput: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        x_cur     <= x_cur + step_q;
                        remaining <= remaining - 8'd1;
`ifdef POLY_SWEEP_ACCUM_EN
                        accum     <= accum + 16'(res_data);
`endif
                        if (remaining == 8'd1) begin
                            done  <= 1'b1;
                            state <= StFinish;
                        end else begin
                            idx       <= OP_A;
                            eval_data <= a_q;
                            state     <= StDrive;
                        end
                    end
                end
                StFinish: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_sweep_driver.sv
// Scoreboard bench for poly_sweep_driver with a behavioural part2 model.
module tb_poly_sweep_driver;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       start;
    logic [7:0] coef_a, coef_b, coef_c, x_start, x_step, x_count;
    logic       busy, done, error, eval_go;
    logic [7:0] eval_data, eval_result;
    logic       eval_valid;
    logic       res_valid, res_ready;
    logic [7:0] res_data, res_x;
`ifdef POLY_SWEEP_ACCUM_EN
    logic [15:0] accum;
`endif

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [7:0]  opq[$];   // expected eval_data at each eval_go rise
    logic [15:0] rq[$];    // expected {res_x, res_data} per transfer

    always #5 Clock = ~Clock;

    poly_sweep_driver dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .start       (start),
        .coef_a      (coef_a),
        .coef_b      (coef_b),
        .coef_c      (coef_c),
        .x_start     (x_start),
        .x_step      (x_step),
        .x_count     (x_count),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .eval_go     (eval_go),
        .eval_data   (eval_data),
        .eval_result (eval_result),
        .eval_valid  (eval_valid),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_x       (res_x)
`ifdef POLY_SWEEP_ACCUM_EN
        ,
        .accum       (accum)
`endif
    );

    // Behavioural part2: loads A,B,C,X on Go, result valid 5 cycles after Go
    // falls on X; valid stays high until the next A is loaded.
    logic [7:0] ma, mb, mc, mx, mres;
    logic [1:0] midx;
    logic       mprev, mvalid, mute;
    int         mlat;

    assign eval_valid  = mvalid && !mute;
    assign eval_result = mres;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ma <= 0; mb <= 0; mc <= 0; mx <= 0; mres <= 0;
            midx <= 0; mprev <= 0; mvalid <= 1'b1; mlat <= 0;
        end else begin
            mprev <= eval_go;
            if (eval_go && !mprev) begin
                case (midx)
                    2'd0: begin ma <= eval_data; mvalid <= 1'b0; end
                    2'd1: mb <= eval_data;
                    2'd2: mc <= eval_data;
                    default: mx <= eval_data;
                endcase
                midx <= midx + 2'd1;
            end
            if (!eval_go && mprev && midx == 2'd0) mlat <= 5;
            if (mlat > 0) begin
                mlat <= mlat - 1;
                if (mlat == 1) begin
                    mvalid <= 1'b1;
                    mres   <= 8'(ma * mx * mx + mb * mx + mc);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Monitor: operand loads, result transfers, stall stability, done pulses.
    logic       pgo = 1'b0, pvalid = 1'b0, pready = 1'b0;
    logic [7:0] pdata = 0, px = 0;
    initial begin
        logic [15:0] e;
        logic [7:0]  eo;
        forever begin
            @(negedge Clock);
            if (done) done_cnt++;
            if (eval_go && !pgo) begin
                if (opq.size() == 0) chk("unexpected_go", 1, 0);
                else begin
                    eo = opq.pop_front();
                    chk("operand", eval_data, eo);
                end
            end
            if (res_valid && pvalid && !pready) begin
                chk("stall_data", res_data, pdata);
                chk("stall_x", res_x, px);
            end
            if (res_valid) chk("go_while_output", eval_go, 0);
            if (res_valid && res_ready) begin
                if (rq.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    e = rq.pop_front();
                    chk("res_x", res_x, e[15:8]);
                    chk("res_data", res_data, e[7:0]);
                end
            end
            pgo = eval_go; pvalid = res_valid; pready = res_ready;
            pdata = res_data; px = res_x;
        end
    end

    task automatic push_ops(input logic [7:0] a, b, c, x);
        opq.push_back(a); opq.push_back(b); opq.push_back(c); opq.push_back(x);
    endtask

    task automatic do_start(input logic [7:0] a, b, c, xs, st, n);
        coef_a = a; coef_b = b; coef_c = c; x_start = xs; x_step = st; x_count = n;
        start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge Clock);
            if (done) break;
        end
        if (k == 400) chk("done_timeout", 0, 1);
    endtask

    // Returns at the negedge where eval_go has just fallen after the 4th load.
    task automatic wait_x_fall();
        int  rises = 0;
        int  k;
        logic pg = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge Clock);
            if (eval_go && !pg) rises++;
            if (!eval_go && pg && rises == 4) break;
            pg = eval_go;
        end
        if (k == 200) chk("x_load_timeout", 0, 1);
    endtask

    task automatic settle_and_check(input string name, input int d0);
        repeat (3) @(posedge Clock);
        #1;
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
        chk({name, "_busy_low"}, busy, 0);
    endtask

    initial begin
        int d0, n, k;
        Reset = 1'b1; start = 1'b0; res_ready = 1'b1; mute = 1'b0;
        coef_a = 0; coef_b = 0; coef_c = 0; x_start = 0; x_step = 0; x_count = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_go", eval_go, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_eval_data", eval_data, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_x", res_x, 0);
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;

        // Single point: 1*16 + 2*4 + 3 = 27.
        d0 = done_cnt;
        push_ops(1, 2, 3, 4); rq.push_back({8'd4, 8'd27});
        do_start(1, 2, 3, 4, 1, 1);
        chk("single_busy", busy, 1);
        wait_done();
        chk("single_error", error, 0);
        settle_and_check("single", d0);

        // Wrap: x = 254, 0, 2 with result = x.
        d0 = done_cnt;
        push_ops(0, 1, 0, 254); push_ops(0, 1, 0, 0); push_ops(0, 1, 0, 2);
        rq.push_back({8'd254, 8'd254}); rq.push_back({8'd0, 8'd0});
        rq.push_back({8'd2, 8'd2});
        do_start(0, 1, 0, 254, 2, 3);
        wait_done();
        settle_and_check("wrap", d0);

        // Backpressure: 2x^2+3x+5 at x=1 -> 10, x=4 -> 49; stall the first point.
        d0 = done_cnt;
        push_ops(2, 3, 5, 1); push_ops(2, 3, 5, 4);
        rq.push_back({8'd1, 8'd10}); rq.push_back({8'd4, 8'd49});
        res_ready = 1'b0;
        do_start(2, 3, 5, 1, 3, 2);
        for (k = 0; k < 200; k++) begin
            @(negedge Clock);
            if (res_valid) break;
        end
        if (k == 200) chk("bp_valid_timeout", 0, 1);
        repeat (10) @(posedge Clock);
        #1 res_ready = 1'b1;
        wait_done();
        settle_and_check("backpressure", d0);

        // Timeout: 1 GAP cycle + 15 WAIT_RES cycles until done.
        d0 = done_cnt;
        mute = 1'b1;
        push_ops(1, 1, 1, 3);
        do_start(1, 1, 1, 3, 1, 2);
        wait_x_fall();
        for (n = 1; n < 100; n++) begin
            @(negedge Clock);
            if (done) break;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_error", error, 1);
        settle_and_check("timeout", d0);
        chk("error_sticky", error, 1);
        mute = 1'b0;

        // Next start clears error.
        d0 = done_cnt;
        push_ops(1, 2, 3, 4); rq.push_back({8'd4, 8'd27});
        do_start(1, 2, 3, 4, 1, 1);
        chk("error_cleared", error, 0);
        wait_done();
        settle_and_check("after_timeout", d0);

        // Empty sweep: done in the cycle right after acceptance, no Go.
        d0 = done_cnt;
        do_start(9, 9, 9, 9, 1, 0);
        @(negedge Clock);
        chk("empty_done", done, 1);
        settle_and_check("empty", d0);

        // Reset during WAIT_RES, then a clean sweep: x^2+x+1 at 2 -> 7.
        push_ops(1, 1, 1, 2);
        do_start(1, 1, 1, 2, 1, 1);
        wait_x_fall();
        repeat (2) @(posedge Clock);
        d0 = done_cnt;
        #1 Reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_go", eval_go, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_eval_data", eval_data, 0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        push_ops(1, 1, 1, 2); rq.push_back({8'd2, 8'd7});
        do_start(1, 1, 1, 2, 1, 1);
        wait_done();
        settle_and_check("post_reset", d0);

        chk("ops_left", opq.size(), 0);
        chk("results_left", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/poly_sweep_driver.md
Name: poly_sweep_driver

Overview:
- Upstream sequencer and downstream collector for the polynomial evaluator `part2`.
- Given coefficients A, B, C and an X sweep definition, it serially feeds A, B, C, X into `part2` using the Go/DataIn handshake.
- After each load it waits for ResultValid and captures DataResult.
- Each result is emitted, paired with its X, on a valid/ready output stream.

Parameters:
- WIDTH, 8, data width of coefficients, X and results; must match `part2`.
- GO_HIGH_CYCLES, 1, cycles eval_go is held high per operand (>=1).
- GO_LOW_CYCLES, 1, cycles eval_go is held low after each operand (>=1).
- TIMEOUT, 15, maximum cycles spent waiting for eval_valid before aborting.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous active-high reset; must also drive `part2` Reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- coef_a, coef_b, coef_c  in  WIDTH  coefficients; captured on accepted start.
- x_start  in  WIDTH  first X; captured on start.
- x_step  in  WIDTH  X increment per point; captured on start.
- x_count  in  8  number of points; 0 means an empty sweep.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse at sweep end, whether normal or aborted.
- error  out  1  sticky timeout flag; cleared on accepted start.
- eval_go  out  1  drives `part2` Go.
- eval_data  out  WIDTH  drives `part2` DataIn.
- eval_result  in  WIDTH  from `part2` DataResult.
- eval_valid  in  1  from `part2` ResultValid.
- res_valid  out  1  output stream valid.
- res_ready  in  1  output stream ready.
- res_data  out  WIDTH  captured result.
- res_x  out  WIDTH  X used to compute res_data.

Behaviour:
- Reset (async):
  - state=IDLE.
  - busy, done, error, eval_go, res_valid = 0.
  - eval_data, res_data, res_x = 0; all internal counters = 0.
- States: IDLE, DRIVE, GAP, WAIT_RES, OUTPUT, FINISH.
- IDLE:
  - start=1 captures all inputs, clears error, sets x_cur=x_start and remaining=x_count.
  - If x_count=0, go to FINISH; else go to DRIVE with operand index 0.
  - start while busy is ignored.
- DRIVE:
  - eval_data = operand[idx], in order A, B, C, x_cur; eval_go=1 for GO_HIGH_CYCLES.
  - eval_data is stable for the whole DRIVE and GAP phase of an operand.
  - Then go to GAP.
- GAP:
  - eval_go=0 for GO_LOW_CYCLES.
  - If idx<3: idx++ and go to DRIVE; else go to WAIT_RES with the timeout counter cleared.
- All four operands are reloaded every point, because `part2` overwrites its A/B registers.
- WAIT_RES:
  - On the first cycle with eval_valid=1, capture res_data=eval_result and res_x=x_cur, then go to OUTPUT.
  - Counter increments each cycle; when it reaches TIMEOUT without valid, set error=1 and go to FINISH, discarding the point.
  - Nominal latency with default parameters: eval_valid is seen 6 cycles after entering WAIT_RES (5 compute cycles + 1).
- OUTPUT:
  - res_valid=1; res_data and res_x are held stable until res_valid&&res_ready (a transfer in the first cycle is allowed).
  - No eval_go activity while stalled.
  - On transfer: res_valid drops, x_cur = x_cur+x_step mod 2^WIDTH (wraps), remaining--.
  - If remaining=0, go to FINISH; else go to DRIVE with idx=0.
- FINISH: done=1 for one cycle, then IDLE.
- eval_valid is ignored outside WAIT_RES. It is legitimately high while `part2` idles in its load-A state.
- Reset mid-operation returns to IDLE immediately; no partial output is produced.

Optional Feature:
- Macro: POLY_SWEEP_ACCUM_EN.
- When defined:
  - Adds output `accum` (16 bits), the sum of all transferred res_data in the current sweep, zero-extended and wrapping mod 2^16.
  - Cleared on accepted start and on reset; valid when done pulses.
- When undefined: the port and logic are absent.

Decomposition:
- Package `poly_pkg` contains:
  - the state enum `sweep_state_t`;
  - the operand index enum `operand_t` (OP_A, OP_B, OP_C, OP_X);
  - the WIDTH default constant.
- Sub-module `poly_go_pulser`:
  - given a load strobe, runs the GO_HIGH/GO_LOW phase counters;
  - reports when the phase is complete.

Test Plan:
- The bench uses a behavioural `part2` model: result = A*x*x+B*x+C mod 256, with 5-cycle compute latency after Go falls on X.
- Single point: A=1, B=2, C=3, x_start=4, x_count=1, res_ready=1 -> eval_data sequence 1,2,3,4, each with 1-cycle eval_go; res_data=27, res_x=4; done pulses once; busy falls.
- Wrap: x_start=254, x_step=2, x_count=3, A=0, B=1, C=0 -> res_x and res_data sequence 254, 0, 2.
- Backpressure: res_ready=0 for 10 cycles on point 1 -> res_valid, res_data and res_x are stable; eval_go stays 0 until the transfer.
- Timeout: model never asserts eval_valid -> error=1 after 15 WAIT_RES cycles; done pulses; no res_valid. A next start clears error.
- Empty sweep and reset:
  - x_count=0 -> done pulses the cycle after IDLE accepts start; eval_go never asserts.
  - Reset asserted during WAIT_RES -> all outputs are 0 immediately; a subsequent sweep completes correctly.
